// File: rtl/branch_pkg.sv
// Shared constants and types for the branch redirect logic: operand width,
// branch funct3 encodings and the redirect FSM state type.
package branch_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode from funct3 and the comparator flags;
// also tells the comparator whether to compare unsigned.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       less,
  input  logic       equal,
  output logic       cond,
  output logic       unsign
);

  // The comparator produces a single less flag, so BLTU/BGEU reuse the
  // signed encodings and only differ in how the comparator is configured.
  assign unsign = funct3[1];

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:            cond = equal;
      F3_BNE:            cond = !equal;
      F3_BLT,  F3_BLTU:  cond = less;
      F3_BGE,  F3_BGEU:  cond = !less;
      default:           cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// EX-stage branch/jump resolution: owns the fetch PC, issues redirects and
// flushes, traps misaligned targets and counts conditional branches.
module branch_redirect_unit
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_exValid,
  input  logic             i_isBranch,
  input  logic             i_isJal,
  input  logic             i_isJalr,
  input  logic [2:0]       i_funct3,
  input  logic             i_brLess,
  input  logic             i_brEqual,
  input  logic [31:0]      i_exPc,
  input  logic [31:0]      i_imm,
  input  logic [31:0]      i_rs1Data,
  output logic             o_brUnsign,
  output logic [31:0]      o_pc,
  output logic             o_flush,
  output logic             o_taken,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_brCnt,
  output logic [CNT_W-1:0] o_takenCnt,
  output logic             o_state
);

  state_t            state, state_next;
  logic [XLEN-1:0]   pend, pend_next, pc_next;
  logic [XLEN-1:0]   jalr_sum, target_raw, target_eff;
  logic              cond, misal, redirect, accepted, flush_raw;

  branch_cond_eval u_cond (
    .funct3 (i_funct3),
    .less   (i_brLess),
    .equal  (i_brEqual),
    .cond   (cond),
    .unsign (o_brUnsign)
  );

  assign jalr_sum   = i_rs1Data + i_imm;
  assign target_raw = i_isJalr ? (jalr_sum & ~32'h1) : (i_exPc + i_imm);
  assign misal      = target_raw[1];
  assign target_eff = misal ? TRAP_VEC : target_raw;

  assign redirect = (state == ST_RUN) && i_exValid &&
                    (i_isJal || i_isJalr || (i_isBranch && cond));
  // A stalled not-taken branch is re-presented, so count it only once it moves.
  assign accepted = (state == ST_RUN) && i_exValid && i_isBranch &&
                    (!i_stall || redirect);

  // Outputs are forced low while reset is held so downstream stages see no
  // spurious flush from stale EX inputs.
  assign o_taken    = redirect && i_reset;
  assign o_misalign = redirect && misal && i_reset;
  assign o_flush    = flush_raw && i_reset;
  assign o_state    = state;

  always_comb begin
    state_next = state;
    pend_next  = pend;
    pc_next    = o_pc;
    flush_raw  = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect) begin
          flush_raw = 1'b1;
          if (i_stall) begin
            pend_next  = target_eff;
            state_next = ST_PEND;
          end else begin
            pc_next = target_eff;
          end
        end else if (!i_stall) begin
          pc_next = o_pc + 32'd4;
        end
      end
      ST_PEND: begin
        flush_raw = 1'b1;
        if (!i_stall) begin
          pc_next    = pend;
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_RUN;
      pend       <= '0;
      o_pc       <= RESET_PC;
      o_brCnt    <= '0;
      o_takenCnt <= '0;
    end else begin
      state      <= state_next;
      pend       <= pend_next;
      o_pc       <= pc_next;
      o_brCnt    <= o_brCnt + {{(CNT_W-1){1'b0}}, accepted};
      o_takenCnt <= o_takenCnt + {{(CNT_W-1){1'b0}}, (accepted && cond)};
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: fetch-PC scoreboard plus
// counter and combinational-output checks.
module tb_branch_redirect_unit;

  logic        i_clk;
  logic        i_reset;
  logic        i_stall;
  logic        i_exValid;
  logic        i_isBranch;
  logic        i_isJal;
  logic        i_isJalr;
  logic [2:0]  i_funct3;
  logic        i_brLess;
  logic        i_brEqual;
  logic [31:0] i_exPc;
  logic [31:0] i_imm;
  logic [31:0] i_rs1Data;
  logic        o_brUnsign;
  logic [31:0] o_pc;
  logic        o_flush;
  logic        o_taken;
  logic        o_misalign;
  logic [31:0] o_brCnt;
  logic [31:0] o_takenCnt;
  logic        o_state;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] br_m   = 0;
  logic [31:0] tk_m   = 0;

  branch_redirect_unit #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100),
    .CNT_W    (32)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_stall    (i_stall),
    .i_exValid  (i_exValid),
    .i_isBranch (i_isBranch),
    .i_isJal    (i_isJal),
    .i_isJalr   (i_isJalr),
    .i_funct3   (i_funct3),
    .i_brLess   (i_brLess),
    .i_brEqual  (i_brEqual),
    .i_exPc     (i_exPc),
    .i_imm      (i_imm),
    .i_rs1Data  (i_rs1Data),
    .o_brUnsign (o_brUnsign),
    .o_pc       (o_pc),
    .o_flush    (o_flush),
    .o_taken    (o_taken),
    .o_misalign (o_misalign),
    .o_brCnt    (o_brCnt),
    .o_takenCnt (o_takenCnt),
    .o_state    (o_state)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push the expected fetch PC, advance one edge, pop and compare.
  task automatic step_pc(input logic [31:0] exp);
    exp_q.push_back(exp);
    @(posedge i_clk);
    #1;
    check("pc", o_pc, exp_q.pop_front());
  endtask

  task automatic check_cnt();
    check("br_cnt", o_brCnt, br_m);
    check("taken_cnt", o_takenCnt, tk_m);
  endtask

  task automatic clear_ex();
    i_exValid  = 1'b0;
    i_isBranch = 1'b0;
    i_isJal    = 1'b0;
    i_isJalr   = 1'b0;
    i_funct3   = 3'b000;
    i_brLess   = 1'b0;
    i_brEqual  = 1'b0;
    i_exPc     = 32'h0;
    i_imm      = 32'h0;
    i_rs1Data  = 32'h0;
  endtask

  task automatic drive_branch(input logic [2:0] f3, input logic lt, input logic eq,
                              input logic [31:0] pc, input logic [31:0] imm);
    clear_ex();
    i_exValid  = 1'b1;
    i_isBranch = 1'b1;
    i_funct3   = f3;
    i_brLess   = lt;
    i_brEqual  = eq;
    i_exPc     = pc;
    i_imm      = imm;
  endtask

  task automatic check_comb(input string tag, input logic flush, input logic taken,
                            input logic misal);
    #1;
    check({tag, "_flush"}, {31'b0, o_flush}, {31'b0, flush});
    check({tag, "_taken"}, {31'b0, o_taken}, {31'b0, taken});
    check({tag, "_misalign"}, {31'b0, o_misalign}, {31'b0, misal});
  endtask

  initial begin
    i_reset = 1'b0;
    i_stall = 1'b0;
    clear_ex();

    // Reset state
    #3;
    check("rst_pc", o_pc, 32'h0);
    check("rst_state", {31'b0, o_state}, 32'h0);
    check_comb("rst", 1'b0, 1'b0, 1'b0);
    check_cnt();

    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    #1;
    check("rel_pc", o_pc, 32'h0);
    step_pc(32'h4);
    step_pc(32'h8);
    step_pc(32'hC);
    check_cnt();

    // BEQ taken
    drive_branch(3'b000, 1'b0, 1'b1, 32'h40, 32'h20);
    check_comb("beq", 1'b1, 1'b1, 1'b0);
    check("beq_unsign", {31'b0, o_brUnsign}, 32'h0);
    br_m++; tk_m++;
    step_pc(32'h60);
    check_cnt();

    // BGEU with less set: not taken, unsigned compare requested
    drive_branch(3'b111, 1'b1, 1'b0, 32'h80, 32'h10);
    check_comb("bgeu", 1'b0, 1'b0, 1'b0);
    check("bgeu_unsign", {31'b0, o_brUnsign}, 32'h1);
    br_m++;
    step_pc(32'h64);
    check_cnt();

    // funct3 010 is never taken even with both flags set
    drive_branch(3'b010, 1'b1, 1'b1, 32'h80, 32'h10);
    check_comb("f3_010", 1'b0, 1'b0, 1'b0);
    br_m++;
    step_pc(32'h68);
    check_cnt();

    // JALR to misaligned target traps
    clear_ex();
    i_exValid = 1'b1; i_isJalr = 1'b1; i_rs1Data = 32'h103; i_imm = 32'h0;
    check_comb("jalr_mis", 1'b1, 1'b1, 1'b1);
    step_pc(32'h100);
    check_cnt();

    // JAL under a 3-cycle stall
    clear_ex();
    i_exValid = 1'b1; i_isJal = 1'b1; i_exPc = 32'h200; i_imm = 32'h80;
    i_stall = 1'b1;
    check_comb("jal_st0", 1'b1, 1'b1, 1'b0);
    step_pc(32'h100);
    check("pend_state", {31'b0, o_state}, 32'h1);
    drive_branch(3'b000, 1'b0, 1'b1, 32'h300, 32'h40);
    check_comb("pend1", 1'b1, 1'b0, 1'b0);
    step_pc(32'h100);
    check_comb("pend2", 1'b1, 1'b0, 1'b0);
    step_pc(32'h100);
    i_stall = 1'b0;
    check_comb("pend3", 1'b1, 1'b0, 1'b0);
    step_pc(32'h280);
    check("run_state", {31'b0, o_state}, 32'h0);
    check_cnt();
    clear_ex();
    step_pc(32'h284);

    // Stalled not-taken BNE counted once
    drive_branch(3'b001, 1'b0, 1'b1, 32'h280, 32'h40);
    i_stall = 1'b1;
    check_comb("bne_st", 1'b0, 1'b0, 1'b0);
    step_pc(32'h284);
    step_pc(32'h284);
    check_cnt();
    i_stall = 1'b0;
    br_m++;
    step_pc(32'h288);
    check_cnt();

    // Stalled taken BLT, then reset in PEND
    drive_branch(3'b100, 1'b1, 1'b0, 32'h288, 32'h400);
    i_stall = 1'b1;
    check_comb("blt_st", 1'b1, 1'b1, 1'b0);
    br_m++; tk_m++;
    step_pc(32'h288);
    check_cnt();
    check("blt_pend", {31'b0, o_state}, 32'h1);
    #2;
    i_reset = 1'b0;
    br_m = 0; tk_m = 0;
    check_comb("rst_pend", 1'b0, 1'b0, 1'b0);
    check("rst_pend_pc", o_pc, 32'h0);
    check("rst_pend_state", {31'b0, o_state}, 32'h0);
    check_cnt();
    @(posedge i_clk);
    #1;
    clear_ex();
    i_stall = 1'b0;
    i_reset = 1'b1;
    step_pc(32'h4);

    // JAL to the last word, then the PC wraps to zero
    i_exValid = 1'b1; i_isJal = 1'b1; i_exPc = 32'hFFFF_FF00; i_imm = 32'hFC;
    check_comb("jal_top", 1'b1, 1'b1, 1'b0);
    step_pc(32'hFFFF_FFFC);
    clear_ex();
    step_pc(32'h0);
    check_cnt();

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
